// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I core: sequences fetch, decode, execute,
// memory and writeback, and drives the datapath strobes from the latched IR.
module rv32i_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        br_cond,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [3:0]  alu_op,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        fault,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int            CW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] wait_r;
    logic [31:0]   instret_r;

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       is_lui_s, is_auipc_s, is_jal_s, is_jalr_s, is_branch_s;
    logic       is_load_s, is_store_s, is_op_imm_s, is_op_s, legal_s;
    logic       timeout_s, dp_valid_s, unused_bits_s;

    logic       imem_req_s, ir_we_s, dmem_req_s, dmem_we_s, pc_we_s, rf_we_s;
    logic [1:0] pc_sel_s, wb_sel_s;
    logic       alu_a_sel_s, alu_b_sel_s;
    logic [3:0] alu_op_s;

    assign opcode_s      = instruction[6:0];
    assign funct3_s      = instruction[14:12];
    assign unused_bits_s = ^{instruction[31], instruction[29:15]};

    assign is_lui_s    = (opcode_s == OPC_LUI);
    assign is_auipc_s  = (opcode_s == OPC_AUIPC);
    assign is_jal_s    = (opcode_s == OPC_JAL);
    assign is_jalr_s   = (opcode_s == OPC_JALR);
    assign is_branch_s = (opcode_s == OPC_BRANCH);
    assign is_load_s   = (opcode_s == OPC_LOAD);
    assign is_store_s  = (opcode_s == OPC_STORE);
    assign is_op_imm_s = (opcode_s == OPC_OP_IMM);
    assign is_op_s     = (opcode_s == OPC_OP);
    assign legal_s     = is_lui_s | is_auipc_s | is_jal_s | is_jalr_s | is_branch_s |
                         is_load_s | is_store_s | is_op_imm_s | is_op_s;

    // A zero limit disables the memory timeout entirely.
    assign timeout_s  = (MEM_TIMEOUT != 0) && (wait_r == LIMIT);
    assign dp_valid_s = (state_r == S_EXEC) || (state_r == S_MEM) || (state_r == S_WB);

    // Next-state and strobe decode.
    always_comb begin
        state_s    = state_r;
        imem_req_s = 1'b0;
        ir_we_s    = 1'b0;
        dmem_req_s = 1'b0;
        dmem_we_s  = 1'b0;
        pc_we_s    = 1'b0;
        pc_sel_s   = 2'd0;
        rf_we_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ready) begin
                    ir_we_s = 1'b1;
                    state_s = S_DECODE;
                end else if (timeout_s) begin
                    state_s = S_FAULT;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (legal_s) begin
                    state_s = S_EXEC;
                end else begin
                    state_s = S_FAULT;
                end
            end
            S_EXEC: begin
                if (is_load_s || is_store_s) begin
                    state_s = S_MEM;
                end else if (is_branch_s) begin
                    pc_we_s  = 1'b1;
                    pc_sel_s = br_cond ? 2'd1 : 2'd0;
                    state_s  = S_FETCH;
                end else begin
                    state_s = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = is_store_s;
                if (dmem_ready) begin
                    if (is_store_s) begin
                        pc_we_s = 1'b1;
                        state_s = S_FETCH;
                    end else begin
                        state_s = S_WB;
                    end
                end else if (timeout_s) begin
                    state_s = S_FAULT;
                end else begin
                    state_s = S_MEM;
                end
            end
            S_WB: begin
                rf_we_s = (instruction[11:7] != 5'd0);
                pc_we_s = 1'b1;
                if (is_jal_s) begin
                    pc_sel_s = 2'd1;
                end else if (is_jalr_s) begin
                    pc_sel_s = 2'd2;
                end else begin
                    pc_sel_s = 2'd0;
                end
                state_s = S_FETCH;
            end
            S_FAULT: state_s = S_FAULT;
            default: state_s = S_FAULT;
        endcase
    end

    // Datapath operand, ALU and writeback selects.
    always_comb begin
        alu_a_sel_s = 1'b0;
        alu_b_sel_s = 1'b0;
        alu_op_s    = 4'b0000;
        wb_sel_s    = 2'd0;
        if (dp_valid_s) begin
            alu_a_sel_s = is_auipc_s;
            alu_b_sel_s = is_op_imm_s | is_load_s | is_store_s | is_jalr_s | is_auipc_s;
            if (is_op_s) begin
                alu_op_s = {instruction[30], funct3_s};
            end else if (is_op_imm_s) begin
                alu_op_s = {(funct3_s == 3'b101) & instruction[30], funct3_s};
            end else if (is_branch_s) begin
                alu_op_s = 4'b1000;
            end else begin
                alu_op_s = 4'b0000;
            end
            if (is_lui_s) begin
                wb_sel_s = 2'd3;
            end else if (is_jal_s || is_jalr_s) begin
                wb_sel_s = 2'd2;
            end else if (is_load_s) begin
                wb_sel_s = 2'd1;
            end else begin
                wb_sel_s = 2'd0;
            end
        end else begin
            alu_op_s = 4'b0000;
        end
    end

    // State, retire counter and memory wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_FETCH;
            wait_r    <= '0;
            instret_r <= 32'd0;
        end else begin
            state_r <= state_s;
            if (pc_we_s) begin
                instret_r <= instret_r + 32'd1;
            end
            if (state_s != state_r) begin
                wait_r <= '0;
            end else if ((wait_r != LIMIT) &&
                         (((state_r == S_FETCH) && !imem_ready) ||
                          ((state_r == S_MEM) && !dmem_ready))) begin
                wait_r <= wait_r + CW'(1);
            end
        end
    end

    // Everything is held quiet while reset is asserted, whatever the inputs do.
    assign imem_req  = rst_n & imem_req_s;
    assign ir_we     = rst_n & ir_we_s;
    assign dmem_req  = rst_n & dmem_req_s;
    assign dmem_we   = rst_n & dmem_we_s;
    assign pc_we     = rst_n & pc_we_s;
    assign rf_we     = rst_n & rf_we_s;
    assign alu_a_sel = rst_n & alu_a_sel_s;
    assign alu_b_sel = rst_n & alu_b_sel_s;
    assign pc_sel    = rst_n ? pc_sel_s : 2'd0;
    assign alu_op    = rst_n ? alu_op_s : 4'd0;
    assign wb_sel    = rst_n ? wb_sel_s : 2'd0;
    assign state     = rst_n ? state_r  : 3'd0;
    assign fault     = rst_n & (state_r == S_FAULT);
    assign instret   = rst_n ? instret_r : 32'd0;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Scoreboard bench for rv32i_multicycle_ctrl: directed instructions push expected
// retire records; a negedge monitor pops and compares on every pc_we.
module tb_rv32i_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        imem_ready, dmem_ready, br_cond;
    logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we;
    logic [1:0]  pc_sel, wb_sel;
    logic        alu_a_sel, alu_b_sel, fault;
    logic [3:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] instret;

    rv32i_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .br_cond(br_cond),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel), .state(state),
        .fault(fault), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        logic [1:0]  psel;
        logic        rfwe;
        logic [3:0]  aop;
        logic        asel;
        logic        bsel;
        logic [1:0]  wbs;
        logic [31:0] iret;
        int          lat;
        int          dreq;
        int          dwe;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", what, act, exp);
        end
    endtask

    // Monitor: measures each instruction from its IR latch and checks it on retire.
    initial begin
        int lat_c, dreq_c, dwe_c, rf_c;
        exp_t e;
        string nm;
        lat_c = 0; dreq_c = 0; dwe_c = 0; rf_c = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lat_c = 0; dreq_c = 0; dwe_c = 0; rf_c = 0;
            end else begin
                if (ir_we) begin
                    lat_c = 0; dreq_c = 0; dwe_c = 0; rf_c = 0;
                end
                lat_c++;
                if (dmem_req) dreq_c++;
                if (dmem_we) dwe_c++;
                if (rf_we) rf_c++;
                if (pc_we) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_retire", 32'd1, 32'd0);
                    end else begin
                        e  = sb_q.pop_front();
                        nm = nm_q.pop_front();
                        chk({nm, ".state"},     32'(state),     32'(e.st));
                        chk({nm, ".pc_sel"},    32'(pc_sel),    32'(e.psel));
                        chk({nm, ".rf_we"},     32'(rf_we),     32'(e.rfwe));
                        chk({nm, ".rf_cycles"}, 32'(rf_c),      32'(e.rfwe));
                        chk({nm, ".alu_op"},    32'(alu_op),    32'(e.aop));
                        chk({nm, ".alu_a_sel"}, 32'(alu_a_sel), 32'(e.asel));
                        chk({nm, ".alu_b_sel"}, 32'(alu_b_sel), 32'(e.bsel));
                        chk({nm, ".wb_sel"},    32'(wb_sel),    32'(e.wbs));
                        chk({nm, ".instret"},   instret,        e.iret);
                        chk({nm, ".latency"},   32'(lat_c),     32'(e.lat));
                        chk({nm, ".dmem_req"},  32'(dreq_c),    32'(e.dreq));
                        chk({nm, ".dmem_we"},   32'(dwe_c),     32'(e.dwe));
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #1;
        chk("reset.outputs_zero", 32'({imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel,
            alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, state, fault} != 21'd0), 32'd0);
        chk("reset.instret", instret, 32'd0);
        @(posedge clk); #1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("reset.imem_req_after", 32'(imem_req), 32'd1);
        chk("reset.state_fault", 32'({state, fault}), 32'd0);
    endtask

    task automatic do_fetch(input logic [31:0] ins, input int fw);
        for (int i = 0; i < fw; i++) begin
            imem_ready = 1'b0;
            @(posedge clk); #1;
        end
        imem_ready = 1'b1;
        @(negedge clk);
        chk("fetch.ir_we", 32'(ir_we), 32'd1);
        @(posedge clk); #1;
        imem_ready = 1'b0;
        instruction = ins;
    endtask

    task automatic run_instr(input string nm, input logic [31:0] ins, input int fw,
                             input int mw, input logic br, input logic [2:0] st,
                             input logic [1:0] psel, input logic rfwe, input logic [3:0] aop,
                             input logic asel, input logic bsel, input logic [1:0] wbs,
                             input logic [31:0] iret, input int lat, input int dreq,
                             input int dwe);
        exp_t e;
        int   mc;
        bit   done;
        e.st = st; e.psel = psel; e.rfwe = rfwe; e.aop = aop; e.asel = asel;
        e.bsel = bsel; e.wbs = wbs; e.iret = iret; e.lat = lat; e.dreq = dreq; e.dwe = dwe;
        sb_q.push_back(e);
        nm_q.push_back(nm);
        do_fetch(ins, fw);
        chk({nm, ".decode"}, 32'(state), 32'd1);
        mc = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done && state != 3'd7; k++) begin
            if (state == 3'd0) begin
                done = 1'b1;
            end else begin
                br_cond = br;
                dmem_ready = (state == 3'd3) && (mc == mw - 1);
                if (state == 3'd3) mc++;
                @(posedge clk); #1;
                dmem_ready = 1'b0;
            end
        end
        chk({nm, ".back_to_fetch"}, 32'(done), 32'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; br_cond = 1'b0;
        instruction = 32'h0;
        do_reset();

        //        name        instr          fw mw br  st    psel  rf    aop      a     b     wb    iret   lat dreq dwe
        run_instr("addi",     32'h02BF0F13, 0, 0, 0, 3'd4, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 32'd0,  4, 0, 0);
        run_instr("add_x0",   32'h01C30033, 0, 0, 0, 3'd4, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd1,  4, 0, 0);
        chk("instret_after_two", instret, 32'd2);
        run_instr("sw",       32'h21D2A023, 0, 3, 0, 3'd3, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 32'd2,  6, 3, 3);
        run_instr("beq_t",    32'h40628063, 0, 0, 1, 3'd2, 2'd1, 1'b0, 4'b1000, 1'b0, 1'b0, 2'd0, 32'd3,  3, 0, 0);
        run_instr("beq_nt",   32'h40628063, 0, 0, 0, 3'd2, 2'd0, 1'b0, 4'b1000, 1'b0, 1'b0, 2'd0, 32'd4,  3, 0, 0);
        run_instr("lw",       32'h0080A283, 1, 1, 0, 3'd4, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 32'd5,  5, 1, 0);
        run_instr("sub",      32'h407302B3, 0, 0, 0, 3'd4, 2'd0, 1'b1, 4'b1000, 1'b0, 1'b0, 2'd0, 32'd6,  4, 0, 0);
        run_instr("srai",     32'h4030D093, 0, 0, 0, 3'd4, 2'd0, 1'b1, 4'b1101, 1'b0, 1'b1, 2'd0, 32'd7,  4, 0, 0);
        run_instr("addi_neg", 32'hC0000093, 0, 0, 0, 3'd4, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 32'd8,  4, 0, 0);
        run_instr("auipc",    32'h00001117, 0, 0, 0, 3'd4, 2'd0, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 32'd9,  4, 0, 0);
        run_instr("lui",      32'h123451B7, 0, 0, 0, 3'd4, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd3, 32'd10, 4, 0, 0);
        run_instr("jal",      32'h000000EF, 0, 0, 0, 3'd4, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 32'd11, 4, 0, 0);
        chk("instret_after_twelve", instret, 32'd12);

        // Reset in the middle of a load's MEM phase: nothing retires.
        do_fetch(32'h0080A283, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("lw_abort.in_mem", 32'({state, dmem_req}), 32'({3'd3, 1'b1}));
        do_reset();

        // Data memory never answers: five MEM cycles, then FAULT.
        do_fetch(32'h0080A283, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("dmem_timeout.waiting", 32'(state), 32'd3);
        end
        @(negedge clk);
        chk("dmem_timeout.fault", 32'({state, fault}), 32'({3'd7, 1'b1}));
        do_reset();

        // Instruction memory never answers: five FETCH cycles, then FAULT.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("imem_timeout.waiting", 32'(state), 32'd0);
        end
        @(negedge clk);
        chk("imem_timeout.fault", 32'({state, fault}), 32'({3'd7, 1'b1}));
        do_reset();

        // Ready arriving on the limit cycle wins over the timeout.
        run_instr("jalr_lim", 32'h000100E7, 4, 0, 0, 3'd4, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 32'd0, 4, 0, 0);
        chk("jalr_lim.no_fault", 32'(fault), 32'd0);

        // Illegal opcode: sticky FAULT that ignores the ready inputs.
        do_fetch(32'h0000007F, 0);
        chk("illegal.decode", 32'(state), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            imem_ready = i[0];
            dmem_ready = ~i[0];
            @(negedge clk);
            chk("illegal.fault_hold", 32'({state, fault, imem_req, ir_we, dmem_req, pc_we, rf_we}),
                32'({3'd7, 1'b1, 5'd0}));
            @(posedge clk); #1;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        do_reset();

        @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv32i_multicycle_ctrl.md
Name: rv32i_multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives PC, instruction-register, ALU-operand, register-file and memory strobes from the latched instruction word. Sits beside the immediate generator and ALU, and handshakes with the instruction and data memories.

Parameters:
MEM_TIMEOUT, 15, max cycles to wait for imem_ready/dmem_ready before entering FAULT; 0 disables the timeout.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
instruction  in  32  current IR contents; valid from DECODE onward
imem_ready  in  1  instruction memory completes the fetch (single-cycle pulse)
dmem_ready  in  1  data memory completes the access (single-cycle pulse)
br_cond  in  1  branch comparison result from the datapath; valid in EXEC
imem_req  out  1  instruction fetch request (level)
ir_we  out  1  latch instruction memory data into the IR
dmem_req  out  1  data memory request (level)
dmem_we  out  1  data memory write (store)
pc_we  out  1  PC update strobe
pc_sel  out  2  0 = pc+4, 1 = pc+imm, 2 = ALU result (JALR)
alu_a_sel  out  1  0 = rs1, 1 = pc
alu_b_sel  out  1  0 = rs2, 1 = imm
alu_op  out  4  ALU operation code
rf_we  out  1  register file write enable
wb_sel  out  2  0 = alu, 1 = mem, 2 = pc+4, 3 = imm
state  out  3  current state (debug)
fault  out  1  sticky fault flag
instret  out  32  retired-instruction counter

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7. Strobes are Moore/Mealy combinational from state, IR and ready inputs; state, instret and wait counter are registered.
- Reset (rst_n low, asynchronous):
  - state=FETCH, instret=0, wait counter=0.
  - All outputs forced 0 while rst_n is low.
  - Reset mid-instruction aborts it: no retire, pending request dropped.
- FETCH:
  - imem_req=1 until imem_ready.
  - On imem_ready: ir_we=1 in the same cycle; next state DECODE.
- DECODE (1 cycle):
  - Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011.
  - Legal opcode -> EXEC. Any other opcode -> FAULT.
- EXEC (1 cycle):
  - LOAD/STORE -> MEM.
  - BRANCH: pc_we=1, pc_sel = br_cond ? 1 : 0, instret+1; next FETCH.
  - All other opcodes -> WB.
- MEM:
  - dmem_req=1 and dmem_we=(STORE) held stable until dmem_ready.
  - On dmem_ready: STORE -> pc_we=1, pc_sel=0, instret+1, next FETCH; LOAD -> WB.
- WB (1 cycle):
  - rf_we=1 unless instruction[11:7]==0.
  - pc_we=1; pc_sel = 1 for JAL, 2 for JALR, else 0.
  - instret+1; next FETCH.
- FAULT: all strobes 0, fault=1. Only reset exits; all ready inputs are ignored.
- Datapath selects (valid in EXEC, MEM and WB; 0 in FETCH, DECODE and FAULT):
  - alu_a_sel=1 only for AUIPC.
  - alu_b_sel=1 for OP_IMM, LOAD, STORE, JALR, AUIPC.
  - wb_sel: LUI=3, JAL/JALR=2, LOAD=1, else 0.
- alu_op:
  - OP: {instruction[30], funct3}.
  - OP_IMM: {funct3==101 ? instruction[30] : 0, funct3}.
  - BRANCH: 4'b1000 (SUB).
  - All other opcodes: 4'b0000 (ADD).
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle the relevant ready input is low.
  - When counter==MEM_TIMEOUT and ready is still low -> FAULT.
  - Ready in the same cycle as the limit wins (no fault).
- instret wraps from 0xFFFFFFFF to 0.
- Minimum latency with ready on the first cycle:
  - BRANCH: 3 cycles.
  - LUI/AUIPC/JAL/JALR/OP/OP_IMM: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.

Test Plan:
1. Hold rst_n low during MEM of a load, then release -> state=0, instret=0, all strobes 0 during reset; imem_req=1 in the first cycle after release.
2. addi 0x02BF0F13 with imm ready immediately -> states 0,1,2,4; alu_b_sel=1, alu_op=0000; WB has rf_we=1, pc_we=1, pc_sel=0; instret=1. Then add with rd=x0 (0x01C30033) -> rf_we stays 0, instret=2.
3. sw 0x21D2A023 with dmem_ready on the 3rd MEM cycle -> dmem_req=dmem_we=1 for 3 cycles; rf_we never 1; pc_we on the ready cycle; back to FETCH.
4. beq 0x40628063 with br_cond=1 -> EXEC has pc_we=1, pc_sel=1, alu_op=1000; 3 cycles total. Repeat with br_cond=0 -> pc_sel=0.
5. Opcode 0x0000007F -> FAULT after DECODE; fault=1 held for 20 cycles with imem_ready toggling; rst_n clears it.
6. MEM_TIMEOUT=4 with imem_ready held low -> FAULT after 4 wait cycles. Repeat with ready arriving on the limit cycle -> DECODE, no fault.
